// File: rtl/cpu_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_bus_pkg
//  Description : Shared definitions for the operand-bus arbiter, the word mux
//                and the control decoder: arbiter state encoding, mux select
//                constants and the default bus width.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_bus_pkg;

  localparam int WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/bus_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_out_reg
//  Description : Valid/ready output register for the operand bus. Loads a
//                word on load, holds it while downstream stalls, and drops
//                valid once the word is accepted with nothing new behind it.
//  Ports       : CLK, reset - clock, async active-high reset
//                load       - capture din this cycle
//                din        - incoming word
//                ready      - downstream accepts dout this cycle
//                dout/valid - registered word and its valid flag
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_out_reg #(
  parameter int WIDTH = cpu_bus_pkg::WIDTH
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_data  <= din;
      r_valid <= 1'b1;
    end else if (ready) begin
      r_valid <= 1'b0;
    end
  end

  assign dout  = r_data;
  assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/bus_word_mux.sv
`default_nettype none
// ============================================================================
//  Module      : bus_word_mux
//  Description : 2:1 word select feeding the shared operand bus.
//  Ports       : sel - SEL_A picks a, SEL_B picks b
//                a, b - source words
//                y    - selected word
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_word_mux #(
  parameter int WIDTH = cpu_bus_pkg::WIDTH
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  import cpu_bus_pkg::*;

  assign y = (sel == SEL_B) ? b : a;

endmodule
`default_nettype wire

// File: rtl/bus_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_share_arbiter
//  Description : Round-robin arbiter and sequencer for the shared operand
//                bus. Grants one of two requesters, drives the word mux
//                select and registers the selected word into a valid/ready
//                stage. Tenure is capped at MAX_HOLD words only while the
//                other requester is waiting.
//  Ports       : CLK, reset        - clock, async active-high reset
//                req_a/data_a      - requester A handshake and word
//                req_b/data_b      - requester B handshake and word
//                gnt_a/gnt_b       - registered ownership
//                take_a/take_b     - word consumed this cycle (combinational)
//                sel               - registered mux select (0 = A, 1 = B)
//                bus_out/bus_valid - registered bus word and valid
//                bus_ready         - downstream accepts bus_out
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_share_arbiter #(
  parameter int WIDTH    = cpu_bus_pkg::WIDTH,
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             take_a,
  output logic             take_b,
  output logic             sel,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_valid,
  input  logic             bus_ready
);
  import cpu_bus_pkg::*;

  // Count value at which the next take completes a full tenure.
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MAX_HOLD - 1);

  arb_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_sel, w_sel_nxt;
  logic             r_last_b, w_last_b_nxt;   // 1 = B owned the bus last

  logic             w_out_free;
  logic             w_take_any;
  logic             w_cap_hit;
  logic [WIDTH-1:0] w_word;

  assign gnt_a = (r_state == OWN_A);
  assign gnt_b = (r_state == OWN_B);
  assign sel   = r_sel;

  assign w_out_free = !bus_valid || bus_ready;
  assign take_a     = gnt_a && req_a && w_out_free;
  assign take_b     = gnt_b && req_b && w_out_free;
  assign w_take_any = take_a || take_b;
  assign w_cap_hit  = w_take_any && (r_cnt == c_cnt_last);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_sel    <= SEL_A;
      r_last_b <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sel    <= w_sel_nxt;
      r_last_b <= w_last_b_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_sel_nxt    = r_sel;
    w_last_b_nxt = r_last_b;

    // Counter wraps at MAX_HOLD so an uncontended owner keeps the bus.
    if (w_take_any) begin
      w_cnt_nxt = w_cap_hit ? '0 : r_cnt + 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (req_a && (!req_b || r_last_b)) begin
          w_state_nxt  = OWN_A;
          w_sel_nxt    = SEL_A;
          w_last_b_nxt = 1'b0;
          w_cnt_nxt    = '0;
        end else if (req_b) begin
          w_state_nxt  = OWN_B;
          w_sel_nxt    = SEL_B;
          w_last_b_nxt = 1'b1;
          w_cnt_nxt    = '0;
        end
      end
      OWN_A: begin
        if (!req_a || (w_cap_hit && req_b)) begin
          if (req_b) begin
            w_state_nxt  = OWN_B;
            w_sel_nxt    = SEL_B;
            w_last_b_nxt = 1'b1;
            w_cnt_nxt    = '0;
          end else begin
            w_state_nxt  = IDLE;
          end
        end
      end
      OWN_B: begin
        if (!req_b || (w_cap_hit && req_a)) begin
          if (req_a) begin
            w_state_nxt  = OWN_A;
            w_sel_nxt    = SEL_A;
            w_last_b_nxt = 1'b0;
            w_cnt_nxt    = '0;
          end else begin
            w_state_nxt  = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  bus_word_mux #(.WIDTH(WIDTH)) u_word_mux (
    .sel (r_sel),
    .a   (data_a),
    .b   (data_b),
    .y   (w_word)
  );

  bus_out_reg #(.WIDTH(WIDTH)) u_out_reg (
    .CLK   (CLK),
    .reset (reset),
    .load  (w_take_any),
    .din   (w_word),
    .ready (bus_ready),
    .dout  (bus_out),
    .valid (bus_valid)
  );

endmodule
`default_nettype wire

// File: tb/tb_bus_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_share_arbiter
//  Description : Self-checking bench for bus_share_arbiter. A behavioural
//                model tracks owner, words moved in the current tenure and
//                the output word; every cycle the DUT is compared to it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_share_arbiter;

  localparam int WIDTH    = 16;
  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 4;

  logic             CLK = 1'b0;
  logic             reset = 1'b1;
  logic             req_a = 1'b0, req_b = 1'b0, bus_ready = 1'b0;
  logic [WIDTH-1:0] data_a = '0, data_b = '0;
  logic             gnt_a, gnt_b, take_a, take_b, sel, bus_valid;
  logic [WIDTH-1:0] bus_out;

  bus_share_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .req_a     (req_a),
    .data_a    (data_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .take_a    (take_a),
    .take_b    (take_b),
    .sel       (sel),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owner -1 = nobody, 0 = A, 1 = B.
  int               m_own, m_last, m_words, m_sel;
  bit               m_valid;
  logic [WIDTH-1:0] m_word;
  int               na, nb;   // words delivered per requester

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_last = 1; m_words = 0; m_sel = 0;
    m_valid = 1'b0; m_word = '0;
  endtask

  task automatic grant(input int who);
    m_own = who; m_last = who; m_sel = who; m_words = 0;
  endtask

  // One clock cycle: drive inputs at the falling edge, compare, advance model.
  task automatic step(input bit ra, input logic [WIDTH-1:0] da,
                      input bit rb, input logic [WIDTH-1:0] db, input bit rdy);
    bit free, ta, tb, cap, me_req, oth_req;
    @(negedge CLK);
    req_a = ra; data_a = da; req_b = rb; data_b = db; bus_ready = rdy;
    #1;
    free = !m_valid || rdy;
    ta   = (m_own == 0) && ra && free;
    tb   = (m_own == 1) && rb && free;
    chk("gnt_a",     32'(gnt_a),     32'(m_own == 0));
    chk("gnt_b",     32'(gnt_b),     32'(m_own == 1));
    chk("sel",       32'(sel),       32'(m_sel));
    chk("take_a",    32'(take_a),    32'(ta));
    chk("take_b",    32'(take_b),    32'(tb));
    chk("bus_valid", 32'(bus_valid), 32'(m_valid));
    chk("bus_out",   32'(bus_out),   32'(m_word));

    if (ta) begin m_word = da; m_valid = 1'b1; na++; end
    else if (tb) begin m_word = db; m_valid = 1'b1; nb++; end
    else if (rdy) m_valid = 1'b0;

    if (m_own < 0) begin
      if (ra && rb) grant(m_last == 1 ? 0 : 1);
      else if (ra)  grant(0);
      else if (rb)  grant(1);
    end else begin
      me_req  = (m_own == 0) ? ra : rb;
      oth_req = (m_own == 0) ? rb : ra;
      if (ta || tb) m_words++;
      cap = (ta || tb) && (m_words == MAX_HOLD);
      if (cap) m_words = 0;
      if (!me_req || (cap && oth_req)) begin
        if (oth_req) grant(1 - m_own);
        else m_own = -1;
      end
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge CLK);
    #2 reset = 1'b1;
    #1;
    chk("rst_gnt_a",  32'(gnt_a),     0);
    chk("rst_gnt_b",  32'(gnt_b),     0);
    chk("rst_sel",    32'(sel),       0);
    chk("rst_valid",  32'(bus_valid), 0);
    chk("rst_out",    32'(bus_out),   0);
    chk("rst_take_a", 32'(take_a),    0);
    chk("rst_take_b", 32'(take_b),    0);
    model_reset();
    @(negedge CLK);
    req_a = 1'b0; req_b = 1'b0; bus_ready = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    bit ra, rb;
    na = 0; nb = 0;
    model_reset();
    #12;
    chk("init_gnt_a", 32'(gnt_a), 0);
    chk("init_valid", 32'(bus_valid), 0);
    @(negedge CLK);
    reset = 1'b0;

    // Single requester A with a fixed word.
    for (int i = 0; i < 3; i++) step(1, 16'h1234, 0, 16'h0, 1);
    chk("t1_bus_out", 32'(bus_out), 32'h1234);
    for (int i = 0; i < 2; i++) step(0, 16'h0, 0, 16'h0, 1);

    // Contention from IDLE after reset: A first, then alternating tenures.
    do_reset();
    for (int i = 0; i < 20; i++)
      step(1, 16'hA000 | 16'(na), 1, 16'hB000 | 16'(nb), 1);
    for (int i = 0; i < 2; i++) step(0, 16'h0, 0, 16'h0, 1);

    // Only B for a long run: no drop at the counter wrap.
    for (int i = 0; i < 12; i++) step(0, 16'h0, 1, 16'hB000 | 16'(nb), 1);
    step(0, 16'h0, 0, 16'h0, 1);

    // Backpressure during an A tenure with a changing source word.
    step(1, 16'hA100, 0, 16'h0, 1);
    step(1, 16'hA101, 0, 16'h0, 1);
    for (int i = 0; i < 3; i++) step(1, 16'($urandom), 0, 16'h0, 0);
    for (int i = 0; i < 2; i++) step(1, 16'hA200 | 16'(i), 0, 16'h0, 1);

    // A drops req after its words: IDLE, sel held, valid drains.
    step(0, 16'h0, 0, 16'h0, 1);
    step(0, 16'h0, 0, 16'h0, 1);
    chk("t5_sel_idle", 32'(sel), 0);

    // Reset mid-tenure of B with a word held, then contention again.
    for (int i = 0; i < 3; i++) step(0, 16'h0, 1, 16'hB300 | 16'(i), 1);
    step(0, 16'h0, 1, 16'hB3FF, 0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 16'hA400 | 16'(i), 1, 16'hB400 | 16'(i), 1);

    // Randomised traffic with sticky requests and random stalls.
    ra = 1'b0; rb = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 15) ra = ~ra;
      if ($urandom_range(0, 99) < 15) rb = ~rb;
      if ($urandom_range(0, 999) == 0) do_reset();
      step(ra, 16'($urandom), rb, 16'($urandom), $urandom_range(0, 99) < 70);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
